adder_multicycle: RTL and testbench
===================================

ADDER_MULTICYCLE -- requirements
Module: adder_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SLICE, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RSTN  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  request; accepted only when BUSY=0.
REQ-006 A  input  WIDTH  first operand.
REQ-007 B  input  WIDTH  second operand, already conditionally inverted by the upstream invert stage.
REQ-008 CS  input  1  carry-in; 1 for subtract (completes two's complement), 0 for add.
REQ-009 BUSY  output  1  high while an addition is in progress.
REQ-010 DONE  output  1  single-cycle pulse: RESULT and flags valid.
REQ-011 RESULT  output  WIDTH  A + B + CS, modulo 2^WIDTH.
REQ-012 CARRY  output  1  carry out of bit WIDTH-1 (borrow = ~CARRY on subtract).
REQ-013 OVERFLOW  output  1  signed overflow of A + B + CS.
REQ-014 ZERO  output  1  RESULT equals zero.

Function
REQ-015 States SHALL be IDLE, RUN, FIN.
REQ-016 IDLE: START=1 latches A, B, CS into internal registers, clears slice counter, sets carry register to CS, goes to RUN; BUSY rises next cycle.
REQ-017 RUN: each cycle adds slice k (bits k*SLICE..k*SLICE+SLICE-1) of latched A and B plus carry register, writes slice k of RESULT, updates carry register, increments k.
REQ-018 After slice WIDTH/SLICE-1 is written, state SHALL go to FIN.
REQ-019 FIN: DONE=1, BUSY=0 for exactly one cycle, then IDLE; START sampled in FIN SHALL be accepted as in IDLE (back-to-back issue).
REQ-020 Latency: START sampled at edge t -> DONE high in cycle after edge t+WIDTH/SLICE (4 cycles, default parameters); issue interval WIDTH/SLICE+1 cycles.
REQ-021 START while BUSY=1 SHALL be ignored; operand inputs SHALL not affect an operation after latching.
REQ-022 CARRY = final carry register; OVERFLOW = (A[MSB]==B[MSB]) and (RESULT[MSB]!=A[MSB]) on latched operands; ZERO = ~|RESULT.
REQ-023 RESULT, CARRY, OVERFLOW, ZERO SHALL hold their last valid values until the next FIN; intermediate slices of RESULT may change during RUN and are valid only while DONE=1 or after it.
REQ-024 Flags SHALL be registered and valid in the same cycle DONE=1.

Reset
REQ-025 RSTN=0 SHALL immediately force state IDLE, BUSY=0, DONE=0, RESULT=0, CARRY=0, OVERFLOW=0, ZERO=0, counter and carry register 0, independent of CLK.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation with no DONE pulse; first START after RSTN release is accepted normally.

Structure
REQ-027 A shared package SHALL hold the state enumeration and default WIDTH/SLICE constants.
REQ-028 Per-slice arithmetic SHALL be one combinational sub-module adder_slice (SLICE-bit ripple add, carry in/out), instantiated once and reused each cycle.
REQ-029 Counter width SHALL be clog2(WIDTH/SLICE), minimum 1.

Verification
REQ-030 A=0x00000005, B=0x00000003, CS=0 -> DONE 4 cycles after START, RESULT=0x00000008, CARRY=0, OVERFLOW=0, ZERO=0.
REQ-031 Subtract 5-5: A=0x00000005, B=0xFFFFFFFA, CS=1 -> RESULT=0, ZERO=1, CARRY=1, OVERFLOW=0.
REQ-032 A=0x7FFFFFFF, B=0x00000001, CS=0 -> RESULT=0x80000000, OVERFLOW=1, CARRY=0; A=0xFFFFFFFF, B=0x00000001 -> RESULT=0, CARRY=1, OVERFLOW=0.
REQ-033 START held high continuously with changing operands -> one DONE every 5 cycles, each result matching operands sampled at acceptance, mid-run START ignored.
REQ-034 RSTN pulsed low during RUN slice 2 -> all outputs 0 asynchronously, no DONE, next START 0x10+0x20 -> RESULT=0x00000030.

Source files
------------

// File: rtl/adder_multicycle_pkg.sv
// Shared types and defaults for the slice-serial adder.
package adder_multicycle_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  // Slice counter width; a single-slice adder still needs one counter bit.
  function automatic int cnt_width(input int n_slices);
    return (n_slices > 1) ? $clog2(n_slices) : 1;
  endfunction

endpackage

// File: rtl/adder_multicycle_slice.sv
// SLICE-bit ripple-carry adder; pure combinational, reused every RUN cycle.
module adder_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             c_i,
  output logic [SLICE-1:0] s_o,
  output logic             c_o
);

  logic rip;

  always_comb begin
    s_o = '0;
    rip = c_i;
    for (int i = 0; i < SLICE; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ rip;
      rip    = (a_i[i] & b_i[i]) | (rip & (a_i[i] ^ b_i[i]));
    end
    c_o = rip;
  end

endmodule

// File: rtl/adder_multicycle.sv
// Multicycle adder: latches operands, adds one SLICE per cycle, pulses DONE with registered flags.
module adder_multicycle
  import adder_multicycle_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CS,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             ZERO
);

  localparam int            NSL  = WIDTH / SLICE;
  localparam int            CW   = cnt_width(NSL);
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic             busy_q, done_q, carry_q, ovf_q, zero_q;
  logic             accept;
  int               sl_idx;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_co;

  assign accept = START && (state_q != S_RUN);

  always_comb begin
    sl_idx   = int'(cnt_q) * SLICE;
    sl_a     = a_q[sl_idx +: SLICE];
    sl_b     = b_q[sl_idx +: SLICE];
    result_d = result_q;
    result_d[sl_idx +: SLICE] = sl_s;
  end

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a_i (sl_a),
    .b_i (sl_b),
    .c_i (cy_q),
    .s_o (sl_s),
    .c_o (sl_co)
  );

  // Operands are pure data: captured on acceptance, no reset needed.
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_q <= A;
      b_q <= B;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (START) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            cy_q    <= CS;
          end
        end
        S_RUN: begin
          result_q <= result_d;
          cy_q     <= sl_co;
          cnt_q    <= cnt_q + 1'b1;
          // Flags are taken from the fully assembled result on the last slice.
          if (cnt_q == LAST) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            carry_q <= sl_co;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (result_d[WIDTH-1] != a_q[WIDTH-1]);
            zero_q  <= ~|result_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign RESULT   = result_q;
  assign CARRY    = carry_q;
  assign OVERFLOW = ovf_q;
  assign ZERO     = zero_q;

endmodule

// File: tb/tb_adder_multicycle.sv
// Directed and randomized checks of adder_multicycle against an arithmetic reference model.
module tb_adder_multicycle;

  logic        CLK;
  logic        RSTN;
  logic        START;
  logic [31:0] A, B;
  logic        CS;
  logic        BUSY, DONE, CARRY, OVERFLOW, ZERO;
  logic [31:0] RESULT;

  int checks   = 0;
  int failures = 0;

  adder_multicycle #(.WIDTH(32), .SLICE(8)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .START    (START),
    .A        (A),
    .B        (B),
    .CS       (CS),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT),
    .CARRY    (CARRY),
    .OVERFLOW (OVERFLOW),
    .ZERO     (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, zero, carry, result} from plain 33-bit arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic cs);
    logic [32:0] full;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b} + {32'd0, cs};
    ovf  = (a[31] == b[31]) && (full[31] != a[31]);
    return {ovf, (full[31:0] == 32'd0), full[32], full[31:0]};
  endfunction

  task automatic check_flags(input string tag, input logic [34:0] m);
    check({tag, "_result"}, RESULT,   m[31:0]);
    check({tag, "_carry"},  CARRY,    m[32]);
    check({tag, "_zero"},   ZERO,     m[33]);
    check({tag, "_ovf"},    OVERFLOW, m[34]);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where DONE is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cs, input string tag);
    logic [34:0] m;
    int          lat;
    m     = model(a, b, cs);
    START = 1'b1; A = a; B = b; CS = cs;
    @(posedge CLK); #1;
    START = 1'b0; A = $urandom; B = $urandom; CS = 1'($urandom_range(0, 1));
    check({tag, "_busy"}, BUSY, 1'b1);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_busy_fin"}, BUSY, 1'b0);
    check_flags(tag, m);
  endtask

  logic [64:0] ops_q[$];
  int          due_q[$];
  int          next_acc;
  logic        exp_done;
  logic [64:0] op;
  logic [34:0] hold_m;

  initial begin
    RSTN = 1'b0; START = 1'b0; A = '0; B = '0; CS = 1'b0;
    #3;
    check("rst_busy",   BUSY,     1'b0);
    check("rst_done",   DONE,     1'b0);
    check("rst_result", RESULT,   32'd0);
    check("rst_carry",  CARRY,    1'b0);
    check("rst_ovf",    OVERFLOW, 1'b0);
    check("rst_zero",   ZERO,     1'b0);
    @(posedge CLK); @(posedge CLK); #1;
    RSTN = 1'b1;
    @(posedge CLK); #1;

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, "add5p3");
    @(posedge CLK); #1;
    check("pulse_done_low", DONE, 1'b0);
    check("hold_result", RESULT, 32'h0000_0008);
    START = 1'b1; A = $urandom; B = $urandom;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    check("ignored_busy", BUSY, 1'b1);

    for (int n = 0; n < 8 && !DONE; n++) begin
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    run_op(32'h0000_0005, 32'hFFFF_FFFA, 1'b1, "sub5m5");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "pos_ovf");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "wrap");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "neg_ovf");
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), "rand");
    end

    // Continuous START with fresh operands every cycle.
    hold_m   = model(A, B, CS);
    next_acc = 0;
    for (int c = 0; c < 30; c++) begin
      START = (c < 25); A = $urandom; B = $urandom; CS = 1'($urandom_range(0, 1));
      @(posedge CLK);
      if (START && c >= next_acc) begin
        ops_q.push_back({CS, A, B});
        due_q.push_back(c + 4);
        next_acc = c + 5;
      end
      #1;
      exp_done = (due_q.size() > 0) && (due_q[0] == c);
      check("bb_done", DONE, exp_done);
      if (exp_done) begin
        op = ops_q.pop_front();
        void'(due_q.pop_front());
        check_flags("bb", model(op[63:32], op[31:0], op[64]));
      end
    end
    START = 1'b0;
    check("bb_drained", ops_q.size(), 0);

    // Reset in the middle of RUN, after two slices have been written.
    START = 1'b1; A = 32'hFFFF_FFFF; B = 32'h0000_0001; CS = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RSTN = 1'b0;
    #1;
    check("mid_rst_busy",   BUSY,     1'b0);
    check("mid_rst_result", RESULT,   32'd0);
    check("mid_rst_carry",  CARRY,    1'b0);
    check("mid_rst_zero",   ZERO,     1'b0);
    check("mid_rst_ovf",    OVERFLOW, 1'b0);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge CLK); #1;
      check("mid_rst_no_done", DONE, 1'b0);
    end
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
